multicycle_controller: RTL and testbench

- Control FSM for the multi-cycle RISC-V CPU (RV32I subset). It replaces the single-cycle combinational decoder.
- It sequences the shared datapath (single memory port, one ALU, IR/OldPC/Data/ALUOut registers) through fetch, decode, execute, memory and writeback steps.
- It drives all datapath selects and write enables, holds in memory steps until a ready handshake, and counts retired instructions.

---
 rtl/riscv_mc_pkg.sv | 55 +++++
 rtl/alu_decoder.sv | 35 +++
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path:
// FSM states, opcodes, ALU operations and datapath mux selects.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_EXEC_I   = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10,
        ST_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Only beq and bne are implemented.
    function automatic logic branch_funct_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode. The FSM can force ADD (address/PC arithmetic)
// or SUB (branch compare); otherwise funct3/funct7b5 select the op.
// bad_funct_o depends on funct3 alone so DECODE can reject an
// unsupported R/I instruction while the ALU is still forced to ADD.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       is_rtype_i,
    input  logic       force_add_i,
    input  logic       force_sub_i,
    output logic [3:0] alu_control_o,
    output logic       bad_funct_o
);

    // funct decode with the FSM overrides applied last
    always_comb begin
        alu_control_o = ALU_ADD;
        bad_funct_o   = 1'b0;
        case (funct3_i)
            3'b000:  alu_control_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_control_o = ALU_AND;
            3'b110:  alu_control_o = ALU_OR;
            3'b010:  alu_control_o = ALU_SLT;
            default: bad_funct_o   = 1'b1;
        endcase
        if (force_sub_i) begin
            alu_control_o = ALU_SUB;
        end else if (force_add_i) begin
            alu_control_o = ALU_ADD;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath. Sequences fetch,
// decode, execute, memory and writeback over one shared memory port and
// one ALU, holds memory steps until mem_ready, counts retired
// instructions and parks in HALT on anything unsupported.
// Memory handshake: mem_req is the valid; an access completes on the
// cycle mem_req=1 and mem_ready=1; mem_ready with mem_req=0 is ignored.
module multicycle_controller
    import riscv_mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_control,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_retired,
    output logic [3:0]       dbg_state
);

    state_t           state_q, state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic [3:0]       dec_alu_control;
    logic             dec_bad_funct;

    alu_decoder u_alu_decoder (
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .is_rtype_i    (state_q == ST_EXEC_R),
        .force_add_i   (!((state_q == ST_EXEC_R) || (state_q == ST_EXEC_I))),
        .force_sub_i   (state_q == ST_BRANCH),
        .alu_control_o (dec_alu_control),
        .bad_funct_o   (dec_bad_funct)
    );

    // Instructions retire on the last cycle of their sequence
    assign retire = (state_q == ST_MEMWB)
                 || ((state_q == ST_MEMWRITE) && mem_ready)
                 || (state_q == ST_ALUWB)
                 || (state_q == ST_BRANCH);

    // State, sticky illegal flag and retire counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_HALT) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Next-state: opcode and funct3 legality are resolved in DECODE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = ST_MEMADR;
                    OP_R:              state_d = dec_bad_funct ? ST_HALT : ST_EXEC_R;
                    OP_I:              state_d = dec_bad_funct ? ST_HALT : ST_EXEC_I;
                    OP_BRANCH:         state_d = branch_funct_ok(funct3) ? ST_BRANCH : ST_HALT;
                    OP_JAL:            state_d = ST_JAL;
                    default:           state_d = ST_HALT;
                endcase
            end
            ST_MEMADR:   state_d = (opcode == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
            ST_EXEC_R:   state_d = ST_ALUWB;
            ST_EXEC_I:   state_d = ST_ALUWB;
            ST_ALUWB:    state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JAL:      state_d = ST_ALUWB;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Datapath controls per state; everything is held at 0 during reset
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        imm_src    = IMM_I;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req    = 1'b1;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                end
                ST_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    case (opcode)
                        OP_STORE:  imm_src = IMM_S;
                        OP_BRANCH: imm_src = IMM_B;
                        OP_JAL:    imm_src = IMM_J;
                        default:   imm_src = IMM_I;
                    endcase
                end
                ST_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                ST_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                ST_MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                end
                ST_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                ST_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                end
                ST_EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_I;
                end
                ST_ALUWB: begin
                    result_src = RES_ALUOUT;
                    reg_write  = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    result_src = RES_ALUOUT;
                    pc_write   = (funct3 == 3'b000) ? zero :
                                 (funct3 == 3'b001) ? !zero : 1'b0;
                end
                ST_JAL: begin
                    // ALUOut already holds the target; ALU forms OldPC+4 for rd
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALUOUT;
                    pc_write   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign alu_control   = rst_n ? dec_alu_control : ALU_ADD;
    assign illegal       = illegal_q;
    assign instr_retired = retired_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through the FSM with hand-computed control values and latencies.
module tb_multicycle_controller;
    import riscv_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_control;
    logic [2:0]  imm_src;
    logic        illegal;
    logic [31:0] instr_retired;
    logic [3:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .result_src    (result_src),
        .imm_src       (imm_src),
        .illegal       (illegal),
        .instr_retired (instr_retired),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_instr(input logic [31:0] instr);
        opcode   = instr[6:0];
        funct3   = instr[14:12];
        funct7b5 = instr[30];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input state_t exp);
        chk(tag, 32'(dbg_state), 32'(exp));
    endtask

    task automatic run_branch(input string tag, input logic [31:0] instr,
                              input logic z, input logic exp_pc);
        set_instr(instr);
        zero = z;
        settle();
        cyc = 0;
        step();
        step();
        settle();
        chk_state({tag, "_state"}, ST_BRANCH);
        chk({tag, "_pcw"}, 32'(pc_write), 32'(exp_pc));
        chk({tag, "_aluc"}, 32'(alu_control), 32'(ALU_SUB));
        step();
        settle();
        chk({tag, "_lat"}, 32'(cyc), 3);
        chk_state({tag, "_fetch"}, ST_FETCH);
    endtask

    task automatic run_r(input string tag, input logic [31:0] instr, input logic [3:0] exp_alu);
        set_instr(instr);
        settle();
        cyc = 0;
        step();
        step();
        settle();
        chk_state({tag, "_state"}, ST_EXEC_R);
        chk({tag, "_aluc"}, 32'(alu_control), 32'(exp_alu));
        step();
        step();
        settle();
        chk({tag, "_lat"}, 32'(cyc), 4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        settle();
        step();
        rst_n = 1'b1;
        settle();
    endtask

    initial begin
        rst_n = 1'b0;
        set_instr(32'h0);
        zero      = 1'b0;
        mem_ready = 1'b1;
        step();
        step();
        settle();
        // reset: enables forced low even with mem_ready=1 in FETCH
        chk_state("rst_state", ST_FETCH);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_ir_write", 32'(ir_write), 0);
        chk("rst_pc_write", 32'(pc_write), 0);
        chk("rst_alu_src_b", 32'(alu_src_b), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_retired", instr_retired, 0);

        // add x3,x1,x2
        rst_n = 1'b1;
        set_instr(32'h002081B3);
        settle();
        cyc = 0;
        chk("add_f_mem_req", 32'(mem_req), 1);
        chk("add_f_adr_src", 32'(adr_src), 0);
        chk("add_f_ir_write", 32'(ir_write), 1);
        chk("add_f_pc_write", 32'(pc_write), 1);
        chk("add_f_src_b", 32'(alu_src_b), 2);
        chk("add_f_result", 32'(result_src), 2);
        step();
        settle();
        chk_state("add_decode", ST_DECODE);
        chk("add_d_src_a", 32'(alu_src_a), 1);
        chk("add_d_src_b", 32'(alu_src_b), 1);
        step();
        settle();
        chk_state("add_exec", ST_EXEC_R);
        chk("add_e_aluc", 32'(alu_control), 32'(ALU_ADD));
        chk("add_e_src_a", 32'(alu_src_a), 2);
        chk("add_e_src_b", 32'(alu_src_b), 0);
        step();
        settle();
        chk_state("add_aluwb", ST_ALUWB);
        chk("add_wb_reg_write", 32'(reg_write), 1);
        chk("add_wb_result", 32'(result_src), 0);
        step();
        settle();
        chk("add_lat", 32'(cyc), 4);
        chk("add_retired", instr_retired, 1);

        // sub, and/or/slt
        run_r("sub", 32'h402081B3, ALU_SUB);
        run_r("and", 32'h0020F1B3, ALU_AND);
        run_r("or",  32'h0020E1B3, ALU_OR);
        run_r("slt", 32'h0020A1B3, ALU_SLT);
        chk("r_retired", instr_retired, 5);

        // lw x5,8(x0) with three wait cycles
        set_instr(32'h00802283);
        settle();
        cyc = 0;
        step();
        settle();
        chk("lw_d_imm", 32'(imm_src), 0);
        step();
        settle();
        chk_state("lw_memadr", ST_MEMADR);
        chk("lw_a_src_a", 32'(alu_src_a), 2);
        chk("lw_a_mem_req", 32'(mem_req), 0);
        step();
        mem_ready = 1'b0;
        settle();
        chk_state("lw_memread", ST_MEMREAD);
        chk("lw_r_mem_req", 32'(mem_req), 1);
        chk("lw_r_adr_src", 32'(adr_src), 1);
        step();
        step();
        settle();
        chk_state("lw_memread_hold", ST_MEMREAD);
        step();
        mem_ready = 1'b1;
        settle();
        chk_state("lw_memread_4th", ST_MEMREAD);
        step();
        settle();
        chk_state("lw_memwb", ST_MEMWB);
        chk("lw_wb_result", 32'(result_src), 1);
        chk("lw_wb_reg_write", 32'(reg_write), 1);
        step();
        settle();
        chk("lw_lat", 32'(cyc), 8);
        chk("lw_retired", instr_retired, 6);

        // beq / bne, both zero polarities
        run_branch("beq_z1", 32'h00208463, 1'b1, 1'b1);
        run_branch("beq_z0", 32'h00208463, 1'b0, 1'b0);
        run_branch("bne_z1", 32'h00209463, 1'b1, 1'b0);
        run_branch("bne_z0", 32'h00209463, 1'b0, 1'b1);
        chk("br_retired", instr_retired, 10);

        // jal x1,8
        set_instr(32'h008000EF);
        settle();
        cyc = 0;
        step();
        settle();
        chk("jal_d_imm", 32'(imm_src), 3);
        step();
        settle();
        chk_state("jal_state", ST_JAL);
        chk("jal_pc_write", 32'(pc_write), 1);
        chk("jal_src_a", 32'(alu_src_a), 1);
        chk("jal_src_b", 32'(alu_src_b), 2);
        step();
        settle();
        chk_state("jal_aluwb", ST_ALUWB);
        chk("jal_reg_write", 32'(reg_write), 1);
        step();
        settle();
        chk("jal_lat", 32'(cyc), 4);
        chk("jal_retired", instr_retired, 11);

        // sw x5,8(x0) completing immediately
        set_instr(32'h00502423);
        settle();
        cyc = 0;
        step();
        settle();
        chk("sw_d_imm", 32'(imm_src), 1);
        step();
        settle();
        chk("sw_a_imm", 32'(imm_src), 1);
        step();
        settle();
        chk_state("sw_memwrite", ST_MEMWRITE);
        chk("sw_mem_write", 32'(mem_write), 1);
        chk("sw_adr_src", 32'(adr_src), 1);
        step();
        settle();
        chk("sw_lat", 32'(cyc), 4);
        chk("sw_retired", instr_retired, 12);

        // unsupported opcode parks in HALT
        set_instr(32'h0000007F);
        settle();
        step();
        settle();
        chk("ill_decode_flag", 32'(illegal), 0);
        step();
        settle();
        chk_state("ill_state", ST_HALT);
        chk("ill_flag", 32'(illegal), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            settle();
            chk("ill_enables", 32'({mem_req, mem_write, ir_write, pc_write, reg_write}), 0);
            chk("ill_retired", instr_retired, 12);
        end
        do_reset();
        chk("ill_rst_flag", 32'(illegal), 0);
        chk_state("ill_rst_state", ST_FETCH);
        chk("ill_rst_retired", instr_retired, 0);

        // beq-class opcode with funct3 010 is rejected in DECODE
        set_instr(32'h0020A463);
        settle();
        step();
        step();
        settle();
        chk_state("badbr_state", ST_HALT);
        chk("badbr_flag", 32'(illegal), 1);
        do_reset();

        // R-type sll (funct3 001) is rejected
        set_instr(32'h002091B3);
        settle();
        step();
        step();
        settle();
        chk_state("badr_state", ST_HALT);
        do_reset();

        // addi with bit30 set: funct7b5 must not turn it into SUB
        set_instr(32'h40000093);
        settle();
        cyc = 0;
        step();
        step();
        settle();
        chk_state("addi_state", ST_EXEC_I);
        chk("addi_aluc", 32'(alu_control), 32'(ALU_ADD));
        chk("addi_src_b", 32'(alu_src_b), 1);
        step();
        step();
        settle();
        chk("addi_lat", 32'(cyc), 4);
        chk("addi_retired", instr_retired, 1);

        // sw stalled in MEMWRITE, then reset abandons it
        set_instr(32'h00502423);
        settle();
        step();
        step();
        step();
        mem_ready = 1'b0;
        settle();
        chk_state("swab_state", ST_MEMWRITE);
        step();
        settle();
        chk("swab_hold_mem_write", 32'(mem_write), 1);
        chk("swab_hold_retired", instr_retired, 1);
        rst_n = 1'b0;
        settle();
        chk("swab_rst_mem_write", 32'(mem_write), 0);
        chk("swab_rst_mem_req", 32'(mem_req), 0);
        step();
        settle();
        chk_state("swab_fetch", ST_FETCH);
        chk("swab_retired", instr_retired, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
